pc_fetch_ctrl: RTL

Fetch sequencer for the MIPS32 PC datapath. It decides when the PC register loads and which value it loads: reset vector, PC+4, branch target or jump target. It runs the request/acknowledge handshake with instruction memory and presents fetched instructions to decode with a valid/ready handshake. It sits between the PC register, the PC+4 and branch-target adders, instruction memory, and the decode/execute stages.

---
 rtl/pc_fetch_if.sv | 37 +++
 rtl/pc_fetch_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pc_fetch_if.sv
// pc_fetch_if
//   Bundles the PC datapath, instruction-memory and decode handshake signals
//   of the fetch sequencer into one port.
//   master : the fetch controller (drives imem_req/imem_addr, instr/instr_valid,
//            pc_next/pc_we, fetch_err).
//   slave  : the surrounding datapath, memory and decode stage.
interface pc_fetch_if;
    logic [31:0] pc_atual;
    logic [31:0] pc_plus4;
    logic [31:0] pc_branch;
    logic        branch_taken;
    logic        jump;
    logic [31:0] jump_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc_next;
    logic        pc_we;
    logic        fetch_err;

    modport master (
        input  pc_atual, pc_plus4, pc_branch, branch_taken, jump, jump_target,
               stall, imem_ack, imem_data, instr_ready,
        output imem_req, imem_addr, instr, instr_valid, pc_next, pc_we, fetch_err
    );

    modport slave (
        output pc_atual, pc_plus4, pc_branch, branch_taken, jump, jump_target,
               stall, imem_ack, imem_data, instr_ready,
        input  imem_req, imem_addr, instr, instr_valid, pc_next, pc_we, fetch_err
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Fetch sequencer for the MIPS32 PC datapath. Chooses when the PC register
//   loads and with what (reset vector, PC+4, branch or jump target), runs the
//   req/ack handshake with instruction memory and hands fetched words to
//   decode over a valid/ready handshake.
//   Ports:
//     Clk  - clock, rising edge
//     Rst  - asynchronous active-low reset
//     bus  - pc_fetch_if.master: PC inputs, redirects, stall, imem req/ack,
//            instr/valid/ready, pc_next/pc_we, fetch_err
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned MAX_WAIT     = 15
) (
    input  logic      Clk,
    input  logic      Rst,
    pc_fetch_if.master bus
);
    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD, ERR} state_t;

    state_t          state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [31:0]     redir_tgt_q, redir_tgt_d;
    logic            instr_valid_q, instr_valid_d;
    logic            fetch_err_q, fetch_err_d;
    logic            flush_pend_q, flush_pend_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

    logic            redir;
    logic [31:0]     redir_in;
    logic            req_raw;
    logic            pc_we_raw;
    logic [31:0]     pc_next_c;

    // Jump has priority over a branch arriving in the same cycle.
    assign redir    = bus.branch_taken | bus.jump;
    assign redir_in = bus.jump ? bus.jump_target : bus.pc_branch;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q       <= BOOT;
            instr_q       <= '0;
            redir_tgt_q   <= '0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            flush_pend_q  <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            redir_tgt_q   <= redir_tgt_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
            flush_pend_q  <= flush_pend_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        redir_tgt_d   = redir_tgt_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = fetch_err_q;
        flush_pend_d  = flush_pend_q;
        wait_cnt_d    = wait_cnt_q;
        req_raw       = 1'b0;
        pc_we_raw     = 1'b0;
        pc_next_c     = bus.pc_plus4;

        unique case (state_q)
            BOOT: begin
                pc_we_raw  = 1'b1;
                pc_next_c  = RESET_VECTOR;
                wait_cnt_d = '0;
                state_d    = FETCH;
            end
            FETCH: begin
                req_raw = 1'b1;
                if (bus.imem_ack) begin
                    wait_cnt_d = '0;
                    if (flush_pend_q || redir) begin
                        // Word fetched from the stale path: drop it and
                        // refetch from the newest target.
                        pc_we_raw    = 1'b1;
                        pc_next_c    = redir ? redir_in : redir_tgt_q;
                        flush_pend_d = 1'b0;
                    end else begin
                        instr_d       = bus.imem_data;
                        instr_valid_d = 1'b1;
                        state_d       = HOLD;
                    end
                end else begin
                    if (redir) begin
                        flush_pend_d = 1'b1;
                        redir_tgt_d  = redir_in;
                    end
                    if (wait_cnt_q == CW'(MAX_WAIT)) begin
                        fetch_err_d = 1'b1;
                        state_d     = ERR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (redir) begin
                    // A redirect wins over acceptance: the held word is on
                    // the wrong path.
                    instr_valid_d = 1'b0;
                    pc_we_raw     = 1'b1;
                    pc_next_c     = redir_in;
                    state_d       = FETCH;
                end else if (bus.instr_ready && !bus.stall) begin
                    instr_valid_d = 1'b0;
                    pc_we_raw     = 1'b1;
                    state_d       = FETCH;
                end
            end
            ERR: begin
                // Sticky until reset.
            end
        endcase
    end

    // Request and PC write are gated by reset so they drop the instant Rst
    // falls, independent of the registered state.
    assign bus.imem_req    = req_raw & Rst;
    assign bus.pc_we       = pc_we_raw & Rst;
    assign bus.pc_next     = pc_next_c;
    assign bus.imem_addr   = bus.pc_atual;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.fetch_err   = fetch_err_q;
endmodule
